// File: rtl/abro_multi.sv
// ---------------------------------------------------------------------------
// abro_multi : parametrised ABRO-style sequence detector.
//
// Watches N event inputs and raises a one-cycle completion pulse on `o` once
// every input has been seen. Events are accepted in any order (ORDERED=0) or
// strictly in index order 0..N-1 (ORDERED=1). After the pulse the block holds
// until restart `r`. With TIMEOUT>0, a partially collected set that sees no
// new event for TIMEOUT cycles drops into a sticky FAULT state.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   ev         in   N      event inputs, sampled every rising edge
//   r          in   1      synchronous restart, highest priority
//   o          out  1      completion pulse (state == EMIT)
//   state      out  2      FSM state: COLLECT=0, EMIT=1, HOLD=2, FAULT=3
//   seen       out  N      bitmap of accepted events
//   fault      out  1      high while in FAULT
//   done_count out  CNT_W  completions, modulo 2^CNT_W
// ---------------------------------------------------------------------------
module abro_multi #(
  parameter int N       = 4,
  parameter int ORDERED = 0,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     ev,
  input  logic             r,
  output logic             o,
  output logic [1:0]       state,
  output logic [N-1:0]     seen,
  output logic             fault,
  output logic [CNT_W-1:0] done_count
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_EMIT    = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_FAULT   = 2'd3;

  // Timer keeps at least one bit so the design elaborates with TIMEOUT=0.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW:0]    TO_LIM   = TIMEOUT[TW:0];
  localparam logic [N-1:0]   ALL_ONES = '1;

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     seen_q, seen_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [N-1:0] next_bit;
  logic [N-1:0] accept;
  logic [N-1:0] seen_grow;
  logic [TW:0]  timer_inc;

  // In ordered mode seen is a contiguous run of low ones, so the lowest
  // clear bit (bit k = popcount(seen)) is the only one that may advance.
  assign next_bit  = ~seen_q & (seen_q + N'(1));
  assign accept    = (ORDERED != 0) ? (ev & next_bit) : (ev & ~seen_q);
  assign seen_grow = seen_q | accept;
  assign timer_inc = {1'b0, timer_q} + (TW + 1)'(1);

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    timer_d = timer_q;
    count_d = count_q;
    if (r) begin
      state_d = S_COLLECT;
      seen_d  = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          seen_d = seen_grow;
          // Completion is checked first so it beats a coincident timeout.
          if (seen_grow == ALL_ONES) begin
            state_d = S_EMIT;
            count_d = count_q + CNT_W'(1);
            timer_d = '0;
          end else if (TIMEOUT > 0) begin
            // Repeats of already-set bits are not in accept, so they do
            // not restart the inactivity timer.
            if ((accept != '0) || (seen_q == '0)) begin
              timer_d = '0;
            end else begin
              timer_d = timer_inc[TW-1:0];
              if (timer_inc == TO_LIM) begin
                state_d = S_FAULT;
              end
            end
          end
        end
        S_EMIT:  state_d = S_HOLD;
        default: ; // HOLD and FAULT wait for r; ev is ignored.
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_COLLECT;
      seen_q  <= '0;
      timer_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      timer_q <= timer_d;
      count_q <= count_d;
    end
  end

  assign o          = (state_q == S_EMIT);
  assign fault      = (state_q == S_FAULT);
  assign state      = state_q;
  assign seen       = seen_q;
  assign done_count = count_q;

endmodule

// File: doc/abro_multi.md
Name: abro_multi

Overview:
- Parametrised successor to the two-input ABRO sequence detector.
- Watches N event inputs and emits a one-cycle pulse on `o` once every input has been seen, either in any order or in strict index order.
- After the pulse it holds until restart input `r`. An optional inactivity timeout drives it into a sticky fault state.
- Sits between the debounced event sources and the controller that consumes `o`, `fault` and `done_count`.

Parameters:
- N, 4: number of event inputs (1..16).
- ORDERED, 0: 0 = events accepted in any order; 1 = events must arrive in index order 0..N-1.
- TIMEOUT, 0: inactivity limit in cycles while partially collected; 0 disables the timeout.
- CNT_W, 8: width of the completion counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ev  in  N  event inputs, sampled every rising edge.
- r  in  1  synchronous restart (the "R" of ABRO).
- o  out  1  completion pulse.
- state  out  2  current FSM state encoding.
- seen  out  N  bitmap of accepted events.
- fault  out  1  high while in the FAULT state.
- done_count  out  CNT_W  number of completions, modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, active-high) forces: state=COLLECT, seen=0, timer=0, o=0, fault=0, done_count=0.
- State encoding: COLLECT=0, EMIT=1, HOLD=2, FAULT=3.
- `o` = (state==EMIT) and `fault` = (state==FAULT). Both are pure Moore decodes of the state register.
- Restart `r` has top priority in every state. On an edge with r=1:
  - next state is COLLECT;
  - seen and timer are cleared;
  - ev values in that same cycle are ignored.
- COLLECT, unordered mode (ORDERED=0): seen_next = seen | ev. Several bits may be accepted in one cycle.
- COLLECT, ordered mode (ORDERED=1):
  - k = number of set bits in seen (seen is always a contiguous run of low-order ones);
  - if ev[k]=1, bit k is set; other ev bits are ignored;
  - at most one bit advances per cycle.
- Completion: if seen_next is all ones, next state is EMIT and done_count increments on that edge (wraps at 2^CNT_W).
  - Latency: o is high for the cycle that starts at the edge after the completing event is sampled.
- EMIT lasts exactly one cycle, then HOLD. seen stays all ones.
- HOLD: ev is ignored. The block stays in HOLD until r.
- Timer (only when TIMEOUT>0), active in COLLECT:
  - resets to 0 when a new bit is accepted or when seen==0;
  - otherwise increments by 1 per cycle;
  - when it would reach TIMEOUT, next state is FAULT.
  - Timer width is clog2(TIMEOUT+1).
- Simultaneous completion and timeout on the same edge: completion wins.
- FAULT: ev is ignored, seen is frozen. The block exits only on r or reset.
- Reset mid-operation: asynchronous return to the reset values in any state, including EMIT (the pulse is truncated).
- Repeated ev on an already-set bit has no effect and does not reset the timer.
- N=1: a single ev[0] produces EMIT on the next edge.

Test Plan:
- Unordered completion, N=4, ORDERED=0: ev=0001, 0100, 1010 on consecutive edges -> seen=0001, 0101, 1111; o=1 exactly one cycle; then state=HOLD; done_count=1.
- Ordered rejection, ORDERED=1: ev=0010 then 0001, 0010, 0100, 1000 ->
  - first pulse ignored (seen=0000);
  - seen grows 0001, 0011, 0111, 1111;
  - o pulses once; ev=1111 in a single cycle advances only one bit.
- Restart priority: ev=1111 and r=1 on the same edge in COLLECT -> state=COLLECT, seen=0, o stays 0. Then r=1 in HOLD -> COLLECT, seen=0.
- Timeout, TIMEOUT=5: ev=0001 then idle -> fault=1 after 5 idle edges (state=3, seen=0001).
  - Next ev=1110 is ignored.
  - r=1 -> COLLECT, fault=0.
  - Completion on the 5th idle edge yields EMIT, not FAULT.
- Counter wrap, CNT_W=2: run 5 full sequences, each followed by r -> done_count steps 1, 2, 3, 0, 1.
- Asynchronous reset: assert reset mid-cycle during EMIT and again during FAULT -> all outputs at reset values immediately, without waiting for a clk edge.
